// File: rtl/perf_event_counter_bank.sv
// Bank of NUM_EVENTS performance counters. Each channel counts either the
// cycles its event line is high (level mode) or its 0->1 edges (edge mode).
// A snapshot copies every live counter into a shadow register in one cycle,
// which gives a consistent view across channels. A request/acknowledge read
// port returns one shadow value and its channel's overflow flag per request.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous reset, active low
//   en         global count enable
//   clr        synchronous clear of live counters and overflow flags
//   evt        raw event lines, one per channel
//   edge_mode  per channel: 1 = count rising edges, 0 = count cycles high
//   snap       copy live counters into the shadow registers
//   rd_req     read request, accepted only while the read port is idle
//   rd_sel     channel index of the read
//   rd_ack     one-cycle pulse; rd_data/rd_ovf are valid while it is high
//   rd_data    shadow value of the selected channel (0 if out of range)
//   rd_ovf     sticky overflow flag of the selected channel (0 if out of range)
//   ovf        live sticky overflow flags
module perf_event_counter_bank #(
  parameter int unsigned NUM_EVENTS = 8,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter bit          SATURATE   = 1'b0,
  localparam int unsigned SEL_W     = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [NUM_EVENTS-1:0] evt,
  input  logic [NUM_EVENTS-1:0] edge_mode,
  input  logic                  snap,
  input  logic                  rd_req,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic                  rd_ack,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  rd_ovf,
  output logic [NUM_EVENTS-1:0] ovf
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } rd_state_t;

  logic [CNT_WIDTH-1:0]  cnt    [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  shadow [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] evt_prev;
  logic [NUM_EVENTS-1:0] inc;

  rd_state_t            state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 ack_d;
  logic [CNT_WIDTH-1:0] data_d;
  logic                 rovf_d;
  logic                 sel_valid;

  // evt_prev tracks evt unconditionally, so toggling en or edge_mode can
  // never manufacture an edge out of a line that was already high.
  assign inc = en ? ((edge_mode & evt & ~evt_prev) | (~edge_mode & evt))
                  : '0;

  // Live counters, overflow flags and shadows. The shadow copy reads the
  // pre-edge counter, so snap together with clr keeps the pre-clear value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
      ovf      <= '0;
      evt_prev <= '0;
    end else begin
      evt_prev <= evt;
      for (int i = 0; i < NUM_EVENTS; i++) begin
        if (snap) begin
          shadow[i] <= cnt[i];
        end
        if (clr) begin
          cnt[i] <= '0;
          ovf[i] <= 1'b0;
        end else if (inc[i]) begin
          if (cnt[i] == CNT_MAX) begin
            ovf[i] <= 1'b1;
            if (!SATURATE) begin
              cnt[i] <= '0;
            end
          end else begin
            cnt[i] <= cnt[i] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  assign sel_valid = (32'(sel_q) < NUM_EVENTS);

  // Read port state register and registered response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rd_ack  <= 1'b0;
      rd_data <= '0;
      rd_ovf  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rd_ack  <= ack_d;
      rd_data <= data_d;
      rd_ovf  <= rovf_d;
    end
  end

  // Read port next state; the shadow is sampled on the LOOKUP->RESP edge,
  // which is the same edge that raises rd_ack for the RESP cycle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ack_d   = 1'b0;
    data_d  = rd_data;
    rovf_d  = rd_ovf;
    unique case (state_q)
      IDLE: begin
        if (rd_req) begin
          sel_d   = rd_sel;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        state_d = RESP;
        ack_d   = 1'b1;
        if (sel_valid) begin
          data_d = shadow[sel_q];
          rovf_d = ovf[sel_q];
        end else begin
          data_d = '0;
          rovf_d = 1'b0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
